apb4_master_arbiter: RTL and testbench
======================================

// Module: apb4_master_arbiter
// PURPOSE
//  Shares one APB4 master bridge among NUM_REQ requesters with round-robin arbitration.
//  Captures the winner's command, drives the bridge's TRANSFER and *_BUS inputs, and
//  tracks the bridge phase (IDLE/SETUP/ACCESS). Returns PRDATA/PSLVERR and a done pulse
//  to the owning requester. Supports back-to-back transfers with no IDLE gap.
// PARAMETERS
//  NUM_REQ     4   number of requesters (2..8)
//  DATA_WIDTH  32  APB data width
//  ADDR_WIDTH  32  APB address width
//  STRB_WIDTH  DATA_WIDTH/8 (localparam)  write strobe width
//  IDX_W       $clog2(NUM_REQ) (localparam)  grant index width
// PORTS
//  PCLK        in   1                   clock; all logic on rising edge
//  PRESET      in   1                   synchronous reset, active-high
//  REQ_VALID   in   NUM_REQ             per-requester request, held until its REQ_DONE
//  REQ_ADDR    in   NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*AW +: AW]
//  REQ_WRITE   in   NUM_REQ             1=write, 0=read
//  REQ_WDATA   in   NUM_REQ*DATA_WIDTH  packed write data
//  REQ_STRB    in   NUM_REQ*STRB_WIDTH  packed write strobes
//  REQ_DONE    out  NUM_REQ             one-hot, 1-cycle completion pulse
//  REQ_RDATA   out  DATA_WIDTH          read data of last completed transfer
//  REQ_ERR     out  1                   PSLVERR of last completed transfer
//  GNT_IDX     out  IDX_W               index of current/last owner
//  BUSY        out  1                   1 while a transfer is in SETUP or ACCESS
//  TRANSFER    out  1                   launch strobe to bridge (combinational)
//  PADDR_BUS   out  ADDR_WIDTH          captured address to bridge
//  PWRITE_BUS  out  1                   captured direction to bridge
//  PWDATA_BUS  out  DATA_WIDTH          captured write data to bridge
//  PSTRB_BUS   out  STRB_WIDTH          captured strobes to bridge
//  PREADY      in   1                   bridge PREADY
//  PRDATA      in   DATA_WIDTH          bridge PRDATA
//  PSLVERR     in   1                   bridge PSLVERR
// BEHAVIOUR
//  - Reset: state=ST_IDLE, rr_ptr=0. All outputs 0: REQ_DONE, REQ_RDATA, REQ_ERR,
//    GNT_IDX, BUSY, TRANSFER and *_BUS. Reset mid-transfer abandons the transfer with no REQ_DONE.
//    The bridge is reset on the same cycle (PRESETn = ~PRESET).
//  - FSM mirrors the bridge phase: ST_IDLE -> ST_SETUP -> ST_ACCESS. ST_ACCESS holds while !PREADY.
//  - eligible = REQ_VALID, with the owner's bit masked in ST_ACCESS.
//  - win = first set bit of eligible, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//  - launch = (ST_IDLE & |eligible) | (ST_ACCESS & PREADY & |eligible).
//  - TRANSFER = launch. It is never high in ST_SETUP or in ST_ACCESS with PREADY=0.
//  - On a launch edge:
//    - Register the win fields into *_BUS; PSTRB_BUS=0 when the command is a read.
//    - GNT_IDX<=win, rr_ptr<=(win+1) mod NUM_REQ, state<=ST_SETUP.
//  - *_BUS hold constant from launch edge until the next launch edge.
//    Requester field changes after launch are ignored.
//  - Completion: ST_ACCESS & PREADY. On that edge:
//    - REQ_RDATA<=PRDATA (writes too), REQ_ERR<=PSLVERR.
//    - REQ_DONE[owner]<=1 for exactly one cycle.
//    - state<=ST_SETUP if launch, else ST_IDLE.
//  - Latency: REQ_VALID rise with FSM idle -> launch same cycle -> SETUP next cycle ->
//    ACCESS the cycle after. Zero-wait slave: REQ_DONE 3 cycles after REQ_VALID rise.
//  - Back-to-back: the next owner's SETUP is the cycle right after completion.
//  - A completing owner may re-assert (keep) REQ_VALID. It loses the current arbitration
//    (masked) but is eligible from the next cycle.
//  - BUSY = state!=ST_IDLE (registered).
//  - rr_ptr wraps NUM_REQ-1 -> 0. Simultaneous requests are served in rr order.
//  - No request is starved: max wait is NUM_REQ-1 transfers.
// TESTING
//  1 Single write: REQ_VALID=0001, ADDR0=0x8000_0010, WDATA0=0xA5A5_0001, STRB0=0xF,
//    zero-wait slave -> TRANSFER 1 cycle, PADDR_BUS=0x8000_0010, REQ_DONE=0001 3 cycles later.
//  2 Read with 2 wait states: PRDATA=0xDEAD_BEEF at PREADY -> REQ_RDATA=0xDEAD_BEEF,
//    REQ_ERR=0, PSTRB_BUS=0, REQ_DONE 5 cycles after request.
//  3 All four request at once from reset -> grants 0,1,2,3 back-to-back.
//    TRANSFER high on each completion cycle, no ST_IDLE between, 4 REQ_DONE pulses 2 cycles apart.
//  4 Owner 1 keeps REQ_VALID high, requester 2 waiting -> next grant 2, then 1.
//    With only 1 requesting -> 1 regranted after one ST_IDLE cycle.
//  5 Slave error: PSLVERR=1 with PREADY -> REQ_ERR=1 and REQ_DONE pulse.
//    Next transfer with PSLVERR=0 -> REQ_ERR=0.
//  6 PRESET asserted in ST_ACCESS -> next cycle all outputs 0, no REQ_DONE, rr_ptr=0.
//    Pending requests relaunch after release.

Source files
------------

// File: rtl/apb4_master_arbiter.sv
// apb4_master_arbiter: round-robin sharing of one APB4 master bridge among NUM_REQ requesters
module apb4_master_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  localparam int STRB_WIDTH = DATA_WIDTH / 8,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic                           PCLK,
  input  logic                           PRESET,
  input  logic [NUM_REQ-1:0]             REQ_VALID,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  REQ_ADDR,
  input  logic [NUM_REQ-1:0]             REQ_WRITE,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  REQ_WDATA,
  input  logic [NUM_REQ*STRB_WIDTH-1:0]  REQ_STRB,
  output logic [NUM_REQ-1:0]             REQ_DONE,
  output logic [DATA_WIDTH-1:0]          REQ_RDATA,
  output logic                           REQ_ERR,
  output logic [IDX_W-1:0]               GNT_IDX,
  output logic                           BUSY,
  output logic                           TRANSFER,
  output logic [ADDR_WIDTH-1:0]          PADDR_BUS,
  output logic                           PWRITE_BUS,
  output logic [DATA_WIDTH-1:0]          PWDATA_BUS,
  output logic [STRB_WIDTH-1:0]          PSTRB_BUS,
  input  logic                           PREADY,
  input  logic [DATA_WIDTH-1:0]          PRDATA,
  input  logic                           PSLVERR
);
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] gnt_q, gnt_d, rr_q, rr_d, win, idx;
  logic [NUM_REQ-1:0] eligible, done_q, done_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, pwdata_q, pwdata_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;
  logic err_q, err_d, pwrite_q, pwrite_d;
  logic found, launch, complete;
  // descending search so the candidate closest to rr_q is the last one written
  always_comb begin
    eligible = REQ_VALID & ~((state_q == ST_ACCESS) ? NUM_REQ'(1) << gnt_q : '0);
    win = '0;
    idx = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IDX_W'((int'(rr_q) + k) % NUM_REQ);
      if (eligible[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  assign complete = (state_q == ST_ACCESS) & PREADY;
  assign launch = found & ((state_q == ST_IDLE) | complete);
  assign TRANSFER = launch & ~PRESET;
  always_comb begin
    state_d = launch ? ST_SETUP : (state_q == ST_SETUP) ? ST_ACCESS :
              (state_q == ST_ACCESS && !PREADY) ? ST_ACCESS : ST_IDLE;
    gnt_d = launch ? win : gnt_q;
    rr_d = launch ? ((win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1) : rr_q;
    done_d = complete ? NUM_REQ'(1) << gnt_q : '0;
    rdata_d = complete ? PRDATA : rdata_q;
    err_d = complete ? PSLVERR : err_q;
    paddr_d = launch ? REQ_ADDR[win*ADDR_WIDTH +: ADDR_WIDTH] : paddr_q;
    pwrite_d = launch ? REQ_WRITE[win] : pwrite_q;
    pwdata_d = launch ? REQ_WDATA[win*DATA_WIDTH +: DATA_WIDTH] : pwdata_q;
    pstrb_d = launch ? (REQ_WRITE[win] ? REQ_STRB[win*STRB_WIDTH +: STRB_WIDTH] : '0) : pstrb_q;
  end
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= ST_IDLE;
      gnt_q <= '0;
      rr_q <= '0;
      done_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      paddr_q <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      rr_q <= rr_d;
      done_q <= done_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      paddr_q <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pstrb_q <= pstrb_d;
    end
  end
  assign REQ_DONE = done_q;
  assign REQ_RDATA = rdata_q;
  assign REQ_ERR = err_q;
  assign GNT_IDX = gnt_q;
  assign BUSY = state_q != ST_IDLE;
  assign PADDR_BUS = paddr_q;
  assign PWRITE_BUS = pwrite_q;
  assign PWDATA_BUS = pwdata_q;
  assign PSTRB_BUS = pstrb_q;
endmodule

// File: tb/tb_apb4_master_arbiter.sv
// tb_apb4_master_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_apb4_master_arbiter;
  localparam int N = 4, DW = 32, AW = 32, SW = 4;
  logic PCLK = 0, PRESET = 1;
  logic [N-1:0] REQ_VALID = '0, REQ_WRITE = '0, REQ_DONE;
  logic [N*AW-1:0] REQ_ADDR = '0;
  logic [N*DW-1:0] REQ_WDATA = '0;
  logic [N*SW-1:0] REQ_STRB = '0;
  logic [DW-1:0] REQ_RDATA, PWDATA_BUS, PRDATA = '0;
  logic [AW-1:0] PADDR_BUS;
  logic [SW-1:0] PSTRB_BUS;
  logic [1:0] GNT_IDX;
  logic REQ_ERR, BUSY, TRANSFER, PWRITE_BUS, PREADY = 0, PSLVERR = 0;
  apb4_master_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .REQ_VALID(REQ_VALID), .REQ_ADDR(REQ_ADDR),
    .REQ_WRITE(REQ_WRITE), .REQ_WDATA(REQ_WDATA), .REQ_STRB(REQ_STRB),
    .REQ_DONE(REQ_DONE), .REQ_RDATA(REQ_RDATA), .REQ_ERR(REQ_ERR), .GNT_IDX(GNT_IDX),
    .BUSY(BUSY), .TRANSFER(TRANSFER), .PADDR_BUS(PADDR_BUS), .PWRITE_BUS(PWRITE_BUS),
    .PWDATA_BUS(PWDATA_BUS), .PSTRB_BUS(PSTRB_BUS), .PREADY(PREADY), .PRDATA(PRDATA),
    .PSLVERR(PSLVERR));
  always #5 PCLK = ~PCLK;
  int n_tests = 0, n_fail = 0;
  // model: bus phase 0=idle 1=setup 2=access, owner, rotation pointer, captured command
  int m_phase = 0, m_own = 0, m_ptr = 0, m_win = -1, acc_cnt = 0, ws = 0;
  bit m_launch = 0, rnd_mode = 0;
  logic [N-1:0] m_done = '0, keep = '0;
  logic [DW-1:0] m_rdata = '0, m_wdata = '0, prdata_v = '0;
  logic [AW-1:0] m_addr = '0;
  logic [SW-1:0] m_strb = '0;
  logic m_err = 0, m_wr = 0, perr_v = 0;
  task automatic model_comb();
    logic [N-1:0] elig;
    elig = REQ_VALID;
    if (m_phase == 2) elig[m_own] = 1'b0;
    m_win = -1;
    for (int k = 0; k < N; k++)
      if (m_win < 0 && elig[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
    m_launch = !PRESET && m_win >= 0 && (m_phase == 0 || (m_phase == 2 && PREADY));
  endtask
  task automatic model_update();
    int nxt;
    if (PRESET) begin
      m_phase = 0; m_own = 0; m_ptr = 0; acc_cnt = 0; m_done = '0; m_rdata = '0; m_err = 0;
      m_addr = '0; m_wr = 0; m_wdata = '0; m_strb = '0;
      return;
    end
    m_done = '0;
    if (m_phase == 2 && PREADY) begin
      m_done[m_own] = 1'b1; m_rdata = PRDATA; m_err = PSLVERR;
    end
    nxt = (m_phase == 1 || (m_phase == 2 && !PREADY)) ? 2 : 0;
    if (m_launch) begin
      m_addr = REQ_ADDR[m_win*AW +: AW];
      m_wr = REQ_WRITE[m_win];
      m_wdata = REQ_WDATA[m_win*DW +: DW];
      m_strb = m_wr ? REQ_STRB[m_win*SW +: SW] : '0;
      m_own = m_win; m_ptr = (m_win + 1) % N; nxt = 1;
    end
    acc_cnt = (m_phase == 2 && nxt == 2) ? acc_cnt + 1 : 0;
    m_phase = nxt;
  endtask
  task automatic tick();
    if (rnd_mode) begin
      PREADY = 1'($urandom_range(0, 1)); PRDATA = $urandom; PSLVERR = 1'($urandom_range(0, 1));
    end else begin
      PREADY = (m_phase == 2) ? (acc_cnt >= ws) : 1'($urandom_range(0, 1));
      PRDATA = prdata_v; PSLVERR = perr_v;
    end
    #1;
    model_comb();
    n_tests++;
    if (TRANSFER !== m_launch) begin n_fail++; $display("FAIL transfer @%0t: got %b want %b", $time, TRANSFER, m_launch); end
    model_update();
    @(posedge PCLK); #1;
    n_tests++;
    if (REQ_DONE !== m_done) begin n_fail++; $display("FAIL req_done @%0t: got %b want %b", $time, REQ_DONE, m_done); end
    n_tests++;
    if ({REQ_RDATA, REQ_ERR} !== {m_rdata, m_err}) begin n_fail++; $display("FAIL rdata_err @%0t: got %h/%b want %h/%b", $time, REQ_RDATA, REQ_ERR, m_rdata, m_err); end
    n_tests++;
    if ({GNT_IDX, BUSY} !== {2'(m_own), m_phase != 0}) begin n_fail++; $display("FAIL gnt_busy @%0t: got %0d/%b want %0d/%b", $time, GNT_IDX, BUSY, m_own, m_phase != 0); end
    n_tests++;
    if ({PADDR_BUS, PWRITE_BUS, PWDATA_BUS, PSTRB_BUS} !== {m_addr, m_wr, m_wdata, m_strb}) begin
      n_fail++; $display("FAIL bus @%0t: got %h %b %h %h want %h %b %h %h", $time, PADDR_BUS, PWRITE_BUS, PWDATA_BUS, PSTRB_BUS, m_addr, m_wr, m_wdata, m_strb);
    end
    for (int i = 0; i < N; i++) if (REQ_DONE[i] && !keep[i]) REQ_VALID[i] = 1'b0;
  endtask
  task automatic set_req(input int i, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d, input logic [SW-1:0] s);
    REQ_ADDR[i*AW +: AW] = a; REQ_WRITE[i] = w; REQ_WDATA[i*DW +: DW] = d; REQ_STRB[i*SW +: SW] = s;
    REQ_VALID[i] = 1'b1;
  endtask
  task automatic drain();
    keep = '0; rnd_mode = 0; ws = 0;
    for (int c = 0; c < 80 && (BUSY || REQ_VALID != '0); c++) tick();
    n_tests++;
    if (BUSY !== 1'b0 || REQ_VALID !== '0) begin n_fail++; $display("FAIL drain timeout: busy %b valid %b want 0/0", BUSY, REQ_VALID); end
  endtask
  task automatic do_reset();
    PRESET = 1; tick(); PRESET = 0;
  endtask
  task automatic test_reset();
    REQ_VALID = '1;
    PRESET = 1; tick(); tick();
    n_tests++;
    if ({REQ_DONE, REQ_RDATA, REQ_ERR, GNT_IDX, BUSY, TRANSFER, PADDR_BUS, PWRITE_BUS, PWDATA_BUS, PSTRB_BUS} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: done %b rdata %h gnt %0d busy %b transfer %b paddr %h want all 0", REQ_DONE, REQ_RDATA, GNT_IDX, BUSY, TRANSFER, PADDR_BUS);
    end
    REQ_VALID = '0; PRESET = 0;
  endtask
  task automatic test_single_write();
    set_req(0, 32'h8000_0010, 1'b1, 32'hA5A5_0001, 4'hF);
    tick();
    n_tests++;
    if (PADDR_BUS !== 32'h8000_0010 || PSTRB_BUS !== 4'hF) begin n_fail++; $display("FAIL single_write_bus: got %h/%h want 80000010/f", PADDR_BUS, PSTRB_BUS); end
    tick(); tick();
    n_tests++;
    if (REQ_DONE !== 4'b0001) begin n_fail++; $display("FAIL single_write_done: got %b want 0001", REQ_DONE); end
    drain();
  endtask
  task automatic test_read_wait();
    ws = 2; prdata_v = 32'hDEAD_BEEF; perr_v = 0;
    set_req(1, 32'h4000_0020, 1'b0, 32'h1234_5678, 4'hF);
    repeat (4) tick();
    n_tests++;
    if (REQ_DONE !== 4'b0000 || PSTRB_BUS !== 4'h0) begin n_fail++; $display("FAIL read_wait_early: done %b strb %h want 0000/0", REQ_DONE, PSTRB_BUS); end
    tick();
    n_tests++;
    if (REQ_DONE !== 4'b0010 || REQ_RDATA !== 32'hDEAD_BEEF || REQ_ERR !== 1'b0) begin
      n_fail++; $display("FAIL read_wait_done: done %b rdata %h err %b want 0010/deadbeef/0", REQ_DONE, REQ_RDATA, REQ_ERR);
    end
    drain();
  endtask
  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 32'h1000_0000 + 32'(i), 1'b1, 32'hC0DE_0000 + 32'(i), 4'h3);
    for (int t = 1; t <= 10; t++) begin
      logic [N-1:0] exp_done;
      exp_done = (t >= 3 && t % 2 == 1 && t <= 9) ? 4'(1 << ((t - 3) / 2)) : 4'b0;
      tick();
      n_tests++;
      if (REQ_DONE !== exp_done || BUSY !== (t <= 8)) begin n_fail++; $display("FAIL b2b_t%0d: done %b busy %b want %b/%b", t, REQ_DONE, BUSY, exp_done, t <= 8); end
      n_tests++;
      if (GNT_IDX !== 2'(t <= 8 ? (t - 1) / 2 : 3)) begin n_fail++; $display("FAIL b2b_gnt_t%0d: got %0d want %0d", t, GNT_IDX, t <= 8 ? (t - 1) / 2 : 3); end
    end
    drain();
  endtask
  task automatic test_keep_valid();
    do_reset();
    keep = 4'b0010;
    set_req(1, 32'h2000_0001, 1'b0, 32'h0, 4'h0);
    tick();
    set_req(2, 32'h2000_0002, 1'b1, 32'h5555_AAAA, 4'hC);
    tick(); tick();
    n_tests++;
    if (GNT_IDX !== 2'd2) begin n_fail++; $display("FAIL keep_next_grant: got %0d want 2", GNT_IDX); end
    tick(); tick();
    n_tests++;
    if (GNT_IDX !== 2'd1) begin n_fail++; $display("FAIL keep_regrant: got %0d want 1", GNT_IDX); end
    tick(); tick();
    n_tests++;
    if (BUSY !== 1'b0) begin n_fail++; $display("FAIL keep_idle_gap: busy %b want 0", BUSY); end
    tick();
    n_tests++;
    if (BUSY !== 1'b1 || GNT_IDX !== 2'd1) begin n_fail++; $display("FAIL keep_relaunch: busy %b gnt %0d want 1/1", BUSY, GNT_IDX); end
    keep = '0;
    drain();
  endtask
  task automatic test_slave_error();
    perr_v = 1;
    set_req(3, 32'h3000_0000, 1'b1, 32'hFFFF_0000, 4'h1);
    repeat (3) tick();
    n_tests++;
    if (REQ_ERR !== 1'b1 || REQ_DONE !== 4'b1000) begin n_fail++; $display("FAIL slverr_set: err %b done %b want 1/1000", REQ_ERR, REQ_DONE); end
    drain();
    perr_v = 0;
    set_req(0, 32'h3000_0004, 1'b0, 32'h0, 4'hF);
    repeat (3) tick();
    n_tests++;
    if (REQ_ERR !== 1'b0 || REQ_DONE !== 4'b0001) begin n_fail++; $display("FAIL slverr_clear: err %b done %b want 0/0001", REQ_ERR, REQ_DONE); end
    drain();
  endtask
  task automatic test_reset_mid();
    ws = 5;
    set_req(2, 32'h5000_0002, 1'b1, 32'h2222_2222, 4'hF);
    tick();
    set_req(3, 32'h5000_0003, 1'b0, 32'h3333_3333, 4'hF);
    tick(); tick();
    PRESET = 1; tick(); PRESET = 0;
    n_tests++;
    if ({REQ_DONE, REQ_RDATA, REQ_ERR, GNT_IDX, BUSY, PADDR_BUS, PWRITE_BUS, PWDATA_BUS, PSTRB_BUS} !== '0) begin
      n_fail++; $display("FAIL reset_mid: done %b gnt %0d busy %b paddr %h want all 0", REQ_DONE, GNT_IDX, BUSY, PADDR_BUS);
    end
    ws = 0;
    tick();
    n_tests++;
    if (GNT_IDX !== 2'd2 || BUSY !== 1'b1) begin n_fail++; $display("FAIL reset_relaunch: gnt %0d busy %b want 2/1", GNT_IDX, BUSY); end
    drain();
  endtask
  task automatic test_random();
    do_reset();
    rnd_mode = 1;
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++)
        if (!REQ_VALID[i] && $urandom_range(0, 3) == 0) set_req(i, $urandom, 1'($urandom), $urandom, 4'($urandom));
      if (m_phase != 0) begin
        REQ_ADDR[m_own*AW +: AW] = $urandom; REQ_WDATA[m_own*DW +: DW] = $urandom;
        REQ_WRITE[m_own] = 1'($urandom); REQ_STRB[m_own*SW +: SW] = 4'($urandom);
      end
      keep = 4'($urandom);
      tick();
    end
    drain();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_single_write();
    test_read_wait();
    test_back_to_back();
    test_keep_valid();
    test_slave_error();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
